// File: rtl/ext_mem_pkg.sv
// ============================================================================
//  Module   : ext_mem_pkg
//  Brief    : Shared types and command-word layout for the external memory
//             controller and its memory model.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package ext_mem_pkg;

  localparam int MAX_BURST   = 16;
  localparam int DATA_W      = 32;
  localparam int ADDR_W      = 27;
  localparam int LEN_W       = $clog2(MAX_BURST);

  // Command word layout on the pad bus during the CMD cycle
  localparam int CMD_WE_BIT  = 31;
  localparam int CMD_LEN_MSB = 30;
  localparam int CMD_LEN_LSB = 27;
  localparam int CMD_ADR_MSB = 26;
  localparam int CMD_ADR_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_WRITE = 3'd2,
    ST_TURN  = 3'd3,
    ST_READ  = 3'd4,
    ST_GAP   = 3'd5
  } state_e;

  // Assemble the command word {we, len, addr}
  function automatic logic [DATA_W-1:0] pack_cmd(
    input logic              we,
    input logic [LEN_W-1:0]  len,
    input logic [ADDR_W-1:0] addr
  );
    logic [DATA_W-1:0] w;
    w = '0;
    w[CMD_WE_BIT]                  = we;
    w[CMD_LEN_MSB:CMD_LEN_LSB]     = len;
    w[CMD_ADR_MSB:CMD_ADR_LSB]     = addr;
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ext_mem_ctrl.sv
// ============================================================================
//  Module   : ext_mem_ctrl
//  Brief    : Burst controller for an off-chip memory on a shared 32-bit pad
//             bus. A command word is followed either by write data driven
//             straight out, or by a bus turnaround and READ_LAT-aligned
//             read sampling. Each burst ends with a one-cycle bus-idle gap.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module ext_mem_ctrl #(
  parameter int READ_LAT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [26:0] req_addr,
  input  logic [3:0]  req_len,
  input  logic [31:0] wdata,
  output logic        wdata_ready,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        done,
  output logic        en_o,
  output logic [31:0] bus_o,
  output logic        bus_oe,
  input  logic [31:0] bus_i
);

  import ext_mem_pkg::*;

  // Number of TURN cycles is READ_LAT-1; the latency counter stops at this value
  localparam logic [LEN_W-1:0] TURN_LAST = LEN_W'(READ_LAT - 2);

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]  lat_q, lat_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              we_q, we_d;
  logic              en_q, en_d;
  logic [DATA_W-1:0] bus_o_q, bus_o_d;
  logic              bus_oe_q, bus_oe_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rdata_valid_q, rdata_valid_d;
  logic              done_q, done_d;

  // Request handshake and write-data strobe are decoded directly from state
  always_comb begin
    req_ready   = (state_q == ST_IDLE);
    wdata_ready = ((state_q == ST_CMD) && we_q) ||
                  ((state_q == ST_WRITE) && (cnt_q != len_q));
  end

  // Next-state and next-output computation for the burst sequencer
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    lat_d         = lat_q;
    len_d         = len_q;
    we_d          = we_q;
    en_d          = en_q;
    bus_o_d       = bus_o_q;
    bus_oe_d      = bus_oe_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    done_d        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        en_d     = 1'b0;
        bus_oe_d = 1'b0;
        bus_o_d  = '0;
        if (req_valid) begin
          state_d  = ST_CMD;
          en_d     = 1'b1;
          bus_oe_d = 1'b1;
          bus_o_d  = pack_cmd(req_we, req_len, req_addr);
          we_d     = req_we;
          len_d    = req_len;
          cnt_d    = '0;
          lat_d    = '0;
        end
      end

      ST_CMD: begin
        if (we_q) begin
          // wdata was strobed during this cycle; it goes out next cycle
          state_d = ST_WRITE;
          bus_o_d = wdata;
        end else begin
          // Release the pads so the memory can drive them
          state_d  = ST_TURN;
          bus_oe_d = 1'b0;
          bus_o_d  = '0;
        end
      end

      ST_WRITE: begin
        if (cnt_q == len_q) begin
          state_d  = ST_GAP;
          en_d     = 1'b0;
          bus_oe_d = 1'b0;
          bus_o_d  = '0;
          cnt_d    = '0;
          done_d   = 1'b1;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          bus_o_d = wdata;
        end
      end

      ST_TURN: begin
        if (lat_q == TURN_LAST) begin
          state_d = ST_READ;
          lat_d   = '0;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end

      ST_READ: begin
        rdata_d       = bus_i;
        rdata_valid_d = 1'b1;
        if (cnt_q == len_q) begin
          state_d = ST_GAP;
          en_d    = 1'b0;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_GAP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d  = ST_IDLE;
        en_d     = 1'b0;
        bus_oe_d = 1'b0;
        bus_o_d  = '0;
        cnt_d    = '0;
        lat_d    = '0;
      end
    endcase
  end

  // State and registered outputs; reset aborts any burst silently
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      lat_q         <= '0;
      len_q         <= '0;
      we_q          <= 1'b0;
      en_q          <= 1'b0;
      bus_o_q       <= '0;
      bus_oe_q      <= 1'b0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      lat_q         <= lat_d;
      len_q         <= len_d;
      we_q          <= we_d;
      en_q          <= en_d;
      bus_o_q       <= bus_o_d;
      bus_oe_q      <= bus_oe_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      done_q        <= done_d;
    end
  end

  assign en_o        = en_q;
  assign bus_o       = bus_o_q;
  assign bus_oe      = bus_oe_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign done        = done_q;

endmodule

`default_nettype wire

// File: tb/tb_ext_mem_ctrl.sv
// ============================================================================
//  Module   : tb_ext_mem_ctrl
//  Brief    : Directed self-checking bench for ext_mem_ctrl (READ_LAT=3 and
//             READ_LAT=2 instances).
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ext_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_valid2, req_we;
  logic [26:0] req_addr;
  logic [3:0]  req_len;
  logic [31:0] wdata, bus_i;

  logic        req_ready, wdata_ready, rdata_valid, done, en_o, bus_oe;
  logic [31:0] rdata, bus_o;
  logic        req_ready2, wdata_ready2, rdata_valid2, done2, en_o2, bus_oe2;
  logic [31:0] rdata2, bus_o2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ext_mem_ctrl #(.READ_LAT(3)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_len(req_len),
    .wdata(wdata), .wdata_ready(wdata_ready), .rdata(rdata),
    .rdata_valid(rdata_valid), .done(done), .en_o(en_o),
    .bus_o(bus_o), .bus_oe(bus_oe), .bus_i(bus_i)
  );

  ext_mem_ctrl #(.READ_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid2), .req_ready(req_ready2),
    .req_we(req_we), .req_addr(req_addr), .req_len(req_len),
    .wdata(wdata), .wdata_ready(wdata_ready2), .rdata(rdata2),
    .rdata_valid(rdata_valid2), .done(done2), .en_o(en_o2),
    .bus_o(bus_o2), .bus_oe(bus_oe2), .bus_i(bus_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled 1ns after the edge
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int strobes, en_cnt, done_cnt, acc, low, bad;
    logic [31:0] last;

    rst = 1'b1; req_valid = 1'b0; req_valid2 = 1'b0; req_we = 1'b0;
    req_addr = '0; req_len = '0; wdata = '0; bus_i = 32'hBAD0BAD0;
    tick; tick;

    // ---------------- reset state ----------------
    chk("rst_en_o",   {31'd0, en_o},        32'd0);
    chk("rst_bus_oe", {31'd0, bus_oe},      32'd0);
    chk("rst_bus_o",  bus_o,                32'd0);
    chk("rst_rdata",  rdata,                32'd0);
    chk("rst_rvalid", {31'd0, rdata_valid}, 32'd0);
    chk("rst_done",   {31'd0, done},        32'd0);
    chk("rst_wready", {31'd0, wdata_ready}, 32'd0);
    rst = 1'b0;
    tick;
    chk("idle_ready", {31'd0, req_ready}, 32'd1);

    // ---------------- single write ----------------
    req_valid = 1'b1; req_we = 1'b1; req_addr = 27'h10; req_len = 4'd0;
    tick;                                    // T+1
    req_valid = 1'b0;
    chk("w1_cmd",    bus_o,                32'h8000_0010);
    chk("w1_cmd_en", {31'd0, en_o},        32'd1);
    chk("w1_cmd_oe", {31'd0, bus_oe},      32'd1);
    chk("w1_wready", {31'd0, wdata_ready}, 32'd1);
    chk("w1_busy",   {31'd0, req_ready},   32'd0);
    wdata = 32'hDEAD_BEEF;
    tick;                                    // T+2
    wdata = 32'h0;
    chk("w1_data",    bus_o,                32'hDEAD_BEEF);
    chk("w1_data_en", {31'd0, en_o},        32'd1);
    chk("w1_data_oe", {31'd0, bus_oe},      32'd1);
    chk("w1_wready0", {31'd0, wdata_ready}, 32'd0);
    tick;                                    // T+3
    chk("w1_gap_en", {31'd0, en_o},   32'd0);
    chk("w1_gap_oe", {31'd0, bus_oe}, 32'd0);
    chk("w1_done",   {31'd0, done},   32'd1);
    tick;                                    // T+4
    chk("w1_done0",  {31'd0, done},      32'd0);
    chk("w1_ready",  {31'd0, req_ready}, 32'd1);

    // ---------------- read burst, READ_LAT=3, len=3 ----------------
    req_valid = 1'b1; req_we = 1'b0; req_addr = 27'h100; req_len = 4'd3;
    tick;                                    // T+1
    req_valid = 1'b0;
    chk("r4_cmd",    bus_o,           32'h1800_0100);
    chk("r4_cmd_oe", {31'd0, bus_oe}, 32'd1);
    tick;                                    // T+2
    chk("r4_t2_oe",  {31'd0, bus_oe}, 32'd0);
    chk("r4_t2_en",  {31'd0, en_o},   32'd1);
    tick;                                    // T+3
    chk("r4_t3_oe",  {31'd0, bus_oe},      32'd0);
    chk("r4_t3_rv",  {31'd0, rdata_valid}, 32'd0);
    tick;                                    // T+4: first sample
    bus_i = 32'h11;
    for (int k = 1; k <= 3; k++) begin
      tick;                                  // T+4+k
      chk("r4_rvalid", {31'd0, rdata_valid}, 32'd1);
      chk("r4_rdata",  rdata,                32'h10 + k);
      chk("r4_en",     {31'd0, en_o},        32'd1);
      bus_i = 32'h11 + k;
    end
    tick;                                    // T+8
    bus_i = 32'hBAD0BAD0;
    chk("r4_last_rv", {31'd0, rdata_valid}, 32'd1);
    chk("r4_last",    rdata,                32'h14);
    chk("r4_done",    {31'd0, done},        32'd1);
    chk("r4_gap_en",  {31'd0, en_o},        32'd0);
    tick;                                    // T+9
    chk("r4_rv0",   {31'd0, rdata_valid}, 32'd0);
    chk("r4_done0", {31'd0, done},        32'd0);

    // ---------------- maximum write, len=15 ----------------
    req_valid = 1'b1; req_we = 1'b1; req_addr = 27'h4000; req_len = 4'd15;
    tick;                                    // T+1
    req_valid = 1'b0;
    chk("mw_len_field", {28'd0, bus_o[30:27]}, 32'hF);
    strobes = 0; en_cnt = 0; done_cnt = 0; last = '0;
    for (int i = 0; i < 22; i++) begin       // cycle T+1+i
      if (en_o) en_cnt++;
      if (done) done_cnt++;
      if (i == 16) last = bus_o;
      if (wdata_ready) begin
        wdata = 32'hA0 + 32'(strobes);
        strobes++;
      end else begin
        wdata = 32'h0;
      end
      tick;
    end
    chk("mw_strobes", 32'(strobes),  32'd16);
    chk("mw_en_cyc",  32'(en_cnt),   32'd17);
    chk("mw_done",    32'(done_cnt), 32'd1);
    chk("mw_lastw",   last,          32'hAF);

    // ---------------- back-to-back writes ----------------
    req_valid = 1'b1; req_we = 1'b1; req_addr = 27'h20; req_len = 4'd1;
    wdata = 32'h55;
    acc = 0; low = 0; bad = 0;
    for (int i = 0; i <= 10; i++) begin
      if (i == 9) req_valid = 1'b0;
      if (req_valid && req_ready) acc++;
      if ((i >= 1 && i <= 4) || (i >= 6 && i <= 9))
        if (req_ready) bad++;
      if (i >= 1 && i <= 5 && !en_o) low++;
      tick;
    end
    chk("b2b_accepts",    32'(acc), 32'd2);
    chk("b2b_ready_busy", 32'(bad), 32'd0);
    chk("b2b_en_low",     32'(low), 32'd2);
    chk("b2b_idle",       {31'd0, req_ready}, 32'd1);

    // ---------------- reset in the middle of a len=7 read ----------------
    req_valid = 1'b1; req_we = 1'b0; req_addr = 27'h200; req_len = 4'd7;
    tick;                                    // T+1
    req_valid = 1'b0;
    tick;                                    // T+2
    tick;                                    // T+3
    tick;                                    // T+4: first sample
    bus_i = 32'h31;
    tick;                                    // T+5: second sample
    chk("ra_rv1",   {31'd0, rdata_valid}, 32'd1);
    chk("ra_rd1",   rdata,                32'h31);
    bus_i = 32'h32;
    rst = 1'b1;
    tick;                                    // T+6
    rst = 1'b0;
    bus_i = 32'hBAD0BAD0;
    chk("ra_en",    {31'd0, en_o},        32'd0);
    chk("ra_oe",    {31'd0, bus_oe},      32'd0);
    chk("ra_rv",    {31'd0, rdata_valid}, 32'd0);
    chk("ra_rdata", rdata,                32'd0);
    chk("ra_done",  {31'd0, done},        32'd0);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick;
      if (done || rdata_valid || en_o) bad++;
    end
    chk("ra_quiet", 32'(bad), 32'd0);
    // Follow-up single-word read must complete normally
    req_valid = 1'b1; req_we = 1'b0; req_addr = 27'h300; req_len = 4'd0;
    tick;                                    // T+1
    req_valid = 1'b0;
    chk("ra2_cmd", bus_o, 32'h0000_0300);
    tick;                                    // T+2
    tick;                                    // T+3
    tick;                                    // T+4
    bus_i = 32'h77;
    tick;                                    // T+5
    bus_i = 32'hBAD0BAD0;
    chk("ra2_rv",   {31'd0, rdata_valid}, 32'd1);
    chk("ra2_data", rdata,                32'h77);
    chk("ra2_done", {31'd0, done},        32'd1);
    tick;

    // ---------------- READ_LAT=2 single-word read ----------------
    req_valid2 = 1'b1; req_we = 1'b0; req_addr = 27'h40; req_len = 4'd0;
    tick;                                    // T+1
    req_valid2 = 1'b0;
    chk("l2_cmd", bus_o2,           32'h0000_0040);
    chk("l2_oe1", {31'd0, bus_oe2}, 32'd1);
    tick;                                    // T+2
    chk("l2_oe0", {31'd0, bus_oe2}, 32'd0);
    tick;                                    // T+3: sample
    bus_i = 32'h5A5A;
    chk("l2_rv_early", {31'd0, rdata_valid2}, 32'd0);
    tick;                                    // T+4
    bus_i = 32'hBAD0BAD0;
    chk("l2_rv",   {31'd0, rdata_valid2}, 32'd1);
    chk("l2_data", rdata2,                32'h5A5A);
    chk("l2_done", {31'd0, done2},        32'd1);
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
